sr_imem_loader: RTL and testbench

Instruction memory plus byte-stream program loader, sitting directly upstream of the single-cycle CPU.
- Feeds the CPU's instruction port: the CPU drives a word address, this block returns combinational instruction data.
- Holds the CPU in reset while a program is streamed in over a valid/ready byte interface.
- Releases the CPU once the program is fully written.

---
 rtl/sr_imem_loader.sv | 140 ++++++++++++++
 tb/tb_sr_imem_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_imem_loader.sv
// Instruction memory with a byte-stream program loader in front of it.
// The CPU is held in reset until the header-declared number of words has been streamed in.
module sr_imem_loader #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [7:0]            inData,
  input  logic                  reload,
  input  logic [31:0]           imAddr,
  output logic [31:0]           imData,
  output logic                  cpuRst,
  output logic                  loadErr,
  output logic [ADDR_WIDTH:0]   loadedWords
);

  localparam int          DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

  typedef enum logic [1:0] {
    S_HDR0 = 2'd0,
    S_HDR1 = 2'd1,
    S_DATA = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_sm;
  state_t              w_next;
  logic [15:0]         r_count;
  logic [15:0]         r_widx;
  logic [1:0]          r_bidx;
  logic [23:0]         r_asm;
  logic [31:0]         r_mem [DEPTH];
  logic [ADDR_WIDTH:0] r_loaded;
  logic                r_err;
  logic                r_cpu_rst;

  logic                w_xfer;
  logic [15:0]         w_hdr_count;
  logic                w_last_byte;
  logic [16:0]         w_widx_inc;
  logic                w_word_done;
  logic                w_in_range;
  logic                w_we;
  logic                w_hit;

  assign inReady     = (r_state != S_RUN);
  assign w_xfer      = inValid && inReady;
  assign w_hdr_count = {inData, r_count[7:0]};
  assign w_last_byte = (r_state == S_DATA) && w_xfer && (r_bidx == 2'd3);
  assign w_widx_inc  = {1'b0, r_widx} + 17'd1;
  // 17-bit compare so a 16-bit word index can never wrap past the count
  assign w_word_done = w_last_byte && (w_widx_inc >= {1'b0, r_count});
  assign w_in_range  = ({1'b0, r_widx} < DEPTH_17);
  assign w_we        = w_last_byte && w_in_range && !reload && !rst;

  // Next-state logic of the load sequencer
  always_comb begin
    w_next_sm = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_xfer) w_next_sm = S_HDR1;
        else        w_next_sm = S_HDR0;
      end
      S_HDR1: begin
        if (w_xfer) w_next_sm = (w_hdr_count == 16'd0) ? S_RUN : S_DATA;
        else        w_next_sm = S_HDR1;
      end
      S_DATA: begin
        if (w_word_done) w_next_sm = S_RUN;
        else             w_next_sm = S_DATA;
      end
      S_RUN:   w_next_sm = S_RUN;
      default: w_next_sm = S_HDR0;
    endcase
    w_next = reload ? S_HDR0 : w_next_sm;
  end

  // State register and registered CPU reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_HDR0;
      r_cpu_rst <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_cpu_rst <= (w_next != S_RUN);
    end
  end

  // Header capture, byte assembly, word index and load status
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      r_count  <= 16'd0;
      r_widx   <= 16'd0;
      r_bidx   <= 2'd0;
      r_asm    <= 24'd0;
      r_loaded <= '0;
      r_err    <= 1'b0;
    end else if (w_xfer) begin
      case (r_state)
        S_HDR0: r_count[7:0] <= inData;
        S_HDR1: begin
          r_count[15:8] <= inData;
          r_widx        <= 16'd0;
          r_bidx        <= 2'd0;
          if (w_hdr_count > 16'(DEPTH)) r_err <= 1'b1;
        end
        S_DATA: begin
          r_bidx <= r_bidx + 2'd1;
          case (r_bidx)
            2'd0:    r_asm[7:0]   <= inData;
            2'd1:    r_asm[15:8]  <= inData;
            2'd2:    r_asm[23:16] <= inData;
            default: begin
              if (w_in_range) r_loaded <= w_widx_inc[ADDR_WIDTH:0];
              if (r_widx != 16'hFFFF) r_widx <= r_widx + 16'd1;
            end
          endcase
        end
        default: r_bidx <= r_bidx;
      endcase
    end
  end

  // Word write on the fourth byte; storage itself is never reset
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_widx[ADDR_WIDTH-1:0]] <= {inData, r_asm};
  end

  assign w_hit       = (imAddr < {{(31 - ADDR_WIDTH){1'b0}}, r_loaded});
  assign imData      = w_hit ? r_mem[imAddr[ADDR_WIDTH-1:0]] : NOP_WORD;
  assign cpuRst      = r_cpu_rst;
  assign loadErr     = r_err;
  assign loadedWords = r_loaded;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Scoreboard bench for sr_imem_loader: stimulus pushes expectations from a word-level
// reference model, a negedge monitor pops and compares them against the DUT outputs.
module tb_sr_imem_loader;
  localparam int          AW    = 6;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [7:0]  inData = 8'd0;
  logic        reload = 1'b0;
  logic [31:0] imAddr = 32'd0;
  logic [31:0] imData;
  logic        cpuRst;
  logic        loadErr;
  logic [AW:0] loadedWords;

  sr_imem_loader #(.ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inData(inData),
    .reload(reload), .imAddr(imAddr), .imData(imData), .cpuRst(cpuRst),
    .loadErr(loadErr), .loadedWords(loadedWords)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          tag;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // reference model: what the memory should hold and what the status outputs should read
  logic [31:0] ref_mem [DEPTH];
  int          ref_loaded = 0;
  bit          ref_err = 1'b0;
  bit          ref_cpu_rst = 1'b1;
  bit          ref_ready = 1'b1;
  logic [31:0] prog_words[$];

  function automatic string kname(int k);
    case (k)
      0: return "imData";
      1: return "cpuRst";
      2: return "loadedWords";
      3: return "loadErr";
      4: return "inReady";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] ref_im(logic [31:0] a);
    if (64'(a) < 64'(ref_loaded)) return ref_mem[a % DEPTH];
    return NOP;
  endfunction

  // monitor: compare every pending expectation against the outputs at the falling edge
  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.kind)
        0:       act = imData;
        1:       act = {31'd0, cpuRst};
        2:       act = {25'd0, loadedWords};
        3:       act = {31'd0, loadErr};
        4:       act = {31'd0, inReady};
        default: act = 32'hxxxxxxxx;
      endcase
      n_checks++;
      if (act === c.exp) n_pass++;
      else $display("FAIL %s tag=%0d got=%h exp=%h", kname(c.kind), c.tag, act, c.exp);
    end
  end

  task automatic push(int kind, int tag, logic [31:0] exp);
    chk_t c;
    c.kind = kind;
    c.tag  = tag;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_state(int tag);
    push(1, tag, 32'(ref_cpu_rst));
    push(2, tag, 32'(ref_loaded));
    push(3, tag, 32'(ref_err));
    push(4, tag, 32'(ref_ready));
    settle();
  endtask

  task automatic probe(logic [31:0] a, int tag);
    imAddr = a;
    push(0, tag, ref_im(a));
    settle();
  endtask

  task automatic probe_all(int tag);
    for (int a = 0; a < DEPTH + 2; a++) probe(32'(a), tag);
    probe(32'h0000_0100, tag);
    probe(32'h8000_0001, tag);
    probe(32'hFFFF_FFFF, tag);
  endtask

  // gaps: 0 = back-to-back, 1 = random idle cycles, 2 = one idle cycle after every byte
  task automatic send_byte(logic [7:0] b, int gaps);
    int n;
    inValid = 1'b1;
    inData  = b;
    tick();
    inValid = 1'b0;
    inData  = 8'($urandom);
    n = (gaps == 1) ? $urandom_range(0, 2) : ((gaps == 2) ? 1 : 0);
    repeat (n) tick();
  endtask

  task automatic model_clear();
    ref_loaded  = 0;
    ref_err     = 1'b0;
    ref_cpu_rst = 1'b1;
    ref_ready   = 1'b1;
  endtask

  task automatic load_prog(int count, int gaps, int tag);
    logic [31:0] wd;
    while (prog_words.size() < count) prog_words.push_back($urandom);
    send_byte(8'(count % 256), gaps);
    exp_state(tag);
    send_byte(8'(count / 256), gaps);
    ref_err = (count > DEPTH);
    if (count == 0) begin
      ref_cpu_rst = 1'b0;
      ref_ready   = 1'b0;
    end
    exp_state(tag);
    for (int w = 0; w < count; w++) begin
      wd = prog_words[w];
      for (int k = 0; k < 4; k++) begin
        send_byte(8'((wd >> (8 * k)) & 32'hFF), gaps);
        if (k == 3) begin
          if (w < DEPTH) begin
            ref_mem[w] = wd;
            ref_loaded = w + 1;
          end
          if (w == count - 1) begin
            ref_cpu_rst = 1'b0;
            ref_ready   = 1'b0;
          end
          imAddr = 32'(w);
          push(0, tag, ref_im(32'(w)));
        end
        exp_state(tag);
      end
    end
    prog_words.delete();
  endtask

  task automatic partial_load(int count, int nbytes);
    send_byte(8'(count % 256), 0);
    send_byte(8'(count / 256), 0);
    for (int i = 0; i < nbytes; i++) send_byte(8'($urandom), 0);
  endtask

  task automatic do_reload(int tag);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    model_clear();
    exp_state(tag);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt;
    // reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    exp_state(1);
    probe(32'd0, 1);

    // directed two-word program, back-to-back bytes
    prog_words.push_back(32'h00500513);
    prog_words.push_back(32'h00a00593);
    load_prog(2, 0, 2);
    probe_all(2);

    // RUN refuses bytes and holds its state
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inData  = 8'($urandom);
      tick();
      exp_state(3);
    end
    inValid = 1'b0;
    probe_all(3);

    // reload from RUN, then a single known word
    do_reload(4);
    probe(32'd0, 4);
    prog_words.push_back(32'hDEADBEEF);
    load_prog(1, 0, 5);
    probe_all(5);

    // empty program
    do_reload(6);
    load_prog(0, 0, 6);
    probe_all(6);

    // alternating valid gaps give the same result
    do_reload(7);
    prog_words.push_back(32'h00500513);
    prog_words.push_back(32'h00a00593);
    load_prog(2, 2, 7);
    probe_all(7);

    // oversize header: 65 words into a 64-word memory
    do_reload(8);
    load_prog(65, 0, 8);
    probe_all(8);

    // reload during DATA with a simultaneous byte that must be dropped
    do_reload(9);
    partial_load(3, 6);
    inValid = 1'b1;
    inData  = 8'h01;
    reload  = 1'b1;
    tick();
    reload  = 1'b0;
    inValid = 1'b0;
    model_clear();
    exp_state(9);
    probe(32'd0, 9);
    prog_words.push_back(32'hDEADBEEF);
    load_prog(1, 0, 10);
    probe_all(10);

    // synchronous reset after five data bytes of a two-word load
    do_reload(11);
    partial_load(2, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    exp_state(11);
    probe(32'd0, 11);
    prog_words.push_back(32'hCAFEF00D);
    load_prog(1, 1, 12);
    probe_all(12);

    // random programs with random gaps
    for (int it = 0; it < 6; it++) begin
      do_reload(20 + it);
      cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 12);
      load_prog(cnt, 1, 20 + it);
      probe_all(20 + it);
    end

    repeat (3) settle();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
